// File: rtl/module_display_7seg.sv
// rtl/module_display_7seg.sv - 4-digit multiplexed 7-segment driver with sequential BCD conversion
//
// Captures an 8-bit product on a valid strobe, converts it to BCD one bit per
// clock (double-dabble), then latches the result into the display registers
// and scans the four common-anode digits with leading-zero blanking.
//
// Optional feature macro: DISPLAY_SIGNED_EN
//   defined   : value is two's complement; digit 3 shows a minus sign for
//               negative values and the magnitude is displayed.
//   undefined : value is unsigned 0..255; digit 3 is always blank.
//
// Parameters:
//   REFRESH_DIV - clk cycles each digit stays lit (>= 2)
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   value in   [7:0] product to display
//   valid in   load strobe, sampled only while idle
//   busy  out  high while a conversion is in progress
//   seg   out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an    out  [3:0] digit anodes, active-low, an[0] is the units digit

module module_display_7seg #(
  parameter int REFRESH_DIV = 27000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       valid,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Internal glyph codes beyond the decimal digits.
  localparam logic [3:0] GLYPH_MINUS = 4'hE;
  localparam logic [3:0] GLYPH_BLANK = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       shift_q, shift_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [11:0]      disp_bcd_q, disp_bcd_d;
  logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;

  logic [7:0]       mag;
  logic             disp_neg;

  // -------------------------------------------------------------------------
  // Magnitude / sign extraction
  // -------------------------------------------------------------------------
`ifdef DISPLAY_SIGNED_EN
  logic sign_work_q, sign_work_d;
  logic disp_sign_q, disp_sign_d;

  // 8'h80 negates to 8'h80, which read unsigned is the required 128.
  assign mag      = value[7] ? (~value + 8'd1) : value;
  assign disp_neg = disp_sign_q;

  always_comb begin
    sign_work_d = sign_work_q;
    disp_sign_d = disp_sign_q;
    if (state_q == S_IDLE && valid) begin
      sign_work_d = value[7];
    end
    if (state_q == S_UPDATE) begin
      disp_sign_d = sign_work_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_work_q <= 1'b0;
      disp_sign_q <= 1'b0;
    end else begin
      sign_work_q <= sign_work_d;
      disp_sign_q <= disp_sign_d;
    end
  end
`else
  assign mag      = value;
  assign disp_neg = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // bit_cnt_q == 7 means this edge performs the eighth shift.
        if (bit_cnt_q == 3'd7) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_CONVERT: busy = 1'b1;
      S_UPDATE:  busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Double-dabble datapath
  // -------------------------------------------------------------------------
  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // The hundreds nibble never exceeds 2 before a shift, so it is never
  // adjusted and its top bit is shifted out as zero.
  logic [10:0] bcd_adj;
  assign bcd_adj = {bcd_q[10:8], dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};

  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    bit_cnt_d  = bit_cnt_q;
    disp_bcd_d = disp_bcd_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          shift_d   = mag;
          bcd_d     = 12'd0;
          bit_cnt_d = 3'd0;
        end
      end
      S_CONVERT: begin
        bcd_d     = {bcd_adj, shift_q[7]};
        shift_d   = {shift_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      S_UPDATE: begin
        // Display registers only change here, so partial BCD is never shown.
        disp_bcd_d = bcd_q;
      end
      default: begin
        shift_d = shift_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= 8'd0;
      bcd_q      <= 12'd0;
      bit_cnt_q  <= 3'd0;
      disp_bcd_q <= 12'd0;
    end else begin
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      disp_bcd_q <= disp_bcd_d;
    end
  end

  // -------------------------------------------------------------------------
  // Refresh scan (free-running, independent of the FSM)
  // -------------------------------------------------------------------------
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
    digit_idx_d   = digit_idx_q;
    if (refresh_cnt_q == CNT_MAX) begin
      refresh_cnt_d = '0;
      digit_idx_d   = digit_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      digit_idx_q   <= 2'd0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      digit_idx_q   <= digit_idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Digit selection, blanking and segment decode
  // -------------------------------------------------------------------------
  logic       hund_blank;
  logic       tens_blank;
  logic [3:0] glyph;

  assign hund_blank = (disp_bcd_q[11:8] == 4'd0);
  assign tens_blank = hund_blank && (disp_bcd_q[7:4] == 4'd0);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (digit_idx_q)
      2'd0: glyph = disp_bcd_q[3:0];
      2'd1: glyph = tens_blank ? GLYPH_BLANK : disp_bcd_q[7:4];
      2'd2: glyph = hund_blank ? GLYPH_BLANK : disp_bcd_q[11:8];
      2'd3: glyph = disp_neg ? GLYPH_MINUS : GLYPH_BLANK;
      default: glyph = GLYPH_BLANK;
    endcase
  end

  always_comb begin
    an              = 4'b1111;
    an[digit_idx_q] = 1'b0;
  end

  always_comb begin
    seg = 7'b1111111;
    case (glyph)
      4'd0:        seg = 7'b1000000;
      4'd1:        seg = 7'b1111001;
      4'd2:        seg = 7'b0100100;
      4'd3:        seg = 7'b0110000;
      4'd4:        seg = 7'b0011001;
      4'd5:        seg = 7'b0010010;
      4'd6:        seg = 7'b0000010;
      4'd7:        seg = 7'b1111000;
      4'd8:        seg = 7'b0000000;
      4'd9:        seg = 7'b0010000;
      GLYPH_MINUS: seg = 7'b0111111;
      default:     seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_module_display_7seg.sv
// tb/tb_module_display_7seg.sv - randomized self-checking bench for module_display_7seg

module tb_module_display_7seg;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic       valid;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;

  module_display_7seg #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .valid (valid),
    .busy  (busy),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset, edge of last accept,
  // captured value, and the value currently on the display.
  int         e;
  int         acc;
  logic [7:0] pend;
  logic [7:0] shown;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_seg(input int g);
    case (g)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments for digit idx when displaying v, from decimal arithmetic.
  function automatic logic [6:0] exp_seg(input logic [7:0] v, input int idx);
    int mag;
    bit neg;
    int h, t, u;
`ifdef DISPLAY_SIGNED_EN
    neg = v[7];
    mag = neg ? 256 - int'(v) : int'(v);
`else
    neg = 1'b0;
    mag = int'(v);
`endif
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    case (idx)
      0: return glyph_seg(u);
      1: return (h == 0 && t == 0) ? glyph_seg(-1) : glyph_seg(t);
      2: return (h == 0) ? glyph_seg(-1) : glyph_seg(h);
      default: return neg ? glyph_seg(10) : glyph_seg(-1);
    endcase
  endfunction

  task automatic check_outputs();
    int idx;
    logic [3:0] an_exp;
    logic exp_busy;
    idx = (e / RD) % 4;
    an_exp = 4'b1111;
    an_exp[idx] = 1'b0;
    exp_busy = (e >= acc) && (e <= acc + 8);
    check("busy", 32'(busy), 32'(exp_busy));
    check("an", 32'(an), 32'(an_exp));
    check("seg", 32'(seg), 32'(exp_seg(shown, idx)));
  endtask

  // One clock: model the edge from the inputs present at it, then check.
  task automatic step();
    @(posedge clk);
    e++;
    if (e == acc + 9) shown = pend;
    if (valid && e > acc + 9) begin
      acc  = e;
      pend = value;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Called at a negedge; asserts reset mid-cycle and checks it takes effect at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_seg", 32'(seg), 32'(7'b1000000));
    check("rst_an", 32'(an), 32'(4'b1110));
    check("rst_busy", 32'(busy), 32'(1'b0));
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    e     = 0;
    acc   = -100;
    pend  = 8'd0;
    shown = 8'd0;
    check_outputs();
  endtask

  task automatic show(input logic [7:0] v);
    valid = 1'b1;
    value = v;
    step();
    valid = 1'b0;
    repeat (9 + 4 * RD) step();
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    value = 8'd0;
    e     = 0;
    acc   = -100;
    pend  = 8'd0;
    shown = 8'd0;
    @(negedge clk);
    do_reset();
    repeat (4 * RD + 2) step();

    show(8'd255);
    show(8'd7);
    show(8'd40);

    // Valid pulses while busy (k+3, k+9) are ignored; k+10 accepts.
    valid = 1'b1; value = 8'd100; step();
    valid = 1'b0; step(); step();
    valid = 1'b1; value = 8'd9; step();
    valid = 1'b0; repeat (5) step();
    valid = 1'b1; value = 8'd9; step();
    step();
    valid = 1'b0;
    repeat (9 + 4 * RD) step();

    // Reset in the middle of a conversion, then a clean conversion.
    valid = 1'b1; value = 8'd200; step();
    valid = 1'b0; repeat (3) step();
    do_reset();
    show(8'd12);

    show(8'hF4);
    show(8'h80);
    show(8'h05);
    show(8'd0);
    show(8'd100);

    // Randomized traffic, including valid held across busy windows.
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      value = 8'($urandom);
      step();
    end
    valid = 1'b0;
    repeat (9 + 4 * RD) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
